muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
// - Owns HI/LO and schedules MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO issued by the decode stage.
// - Drives the external multiplier (fixed latency) and iterative divider (start/busy).
// - Lets unrelated instructions run while an operation is in flight.
// - Stalls the PC only on a HI/LO hazard, replacing the raw div_busy PC-enable gating.
// PARAMETERS
// MUL_LAT   1   cycles from mul_start to valid mul_z (1..15)
// W         32  operand/HI/LO width
// PORTS
// clk           in   1    clock, rising edge
// reset         in   1    synchronous, active-low reset
// op_valid      in   1    decode presents an op this cycle
// op_code       in   3    0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO
// op_a          in   W    rs value (dividend / multiplicand / MTxx data)
// op_b          in   W    rt value (divisor / multiplier)
// rd_req        in   1    MFHI/MFLO in decode
// rd_sel        in   1    0=LO, 1=HI
// rd_data       out  W    selected HI/LO (combinational from registers)
// stall         out  1    hold PC/decode this cycle
// mul_start     out  1    one-cycle launch pulse to multiplier
// mul_signed    out  1    1=MULT, 0=MULTU
// mul_a, mul_b  out  W    latched operands
// mul_z         in   2W   product, sampled MUL_LAT cycles after mul_start
// div_start     out  1    one-cycle launch pulse to divider
// div_signed    out  1    1=DIV, 0=DIVU
// div_dividend, div_divisor  out  W  latched operands
// div_busy      in   1    divider busy, rises the cycle after div_start
// div_q, div_r  in   W    quotient/remainder, valid when busy falls
// hi, lo        out  W    architectural HI/LO
// BEHAVIOUR
// - Reset (reset==0 at edge): state IDLE; hi=lo=0.
//   All start pulses 0; operand latches 0; counter 0.
//   Any in-flight result is discarded (a result arriving later is ignored).
// - Accept: an op is accepted on an edge where op_valid && op_code!=NONE && !stall.
// - stall = (state!=IDLE) && ((op_valid && op_code!=NONE) || rd_req).
//   The completion cycle still stalls; the next op is accepted at the earliest one cycle after HI/LO update.
// - States: IDLE, MUL_WAIT, DIV_WAIT.
//   - IDLE + MULT/MULTU: latch operands and sign; mul_start=1 for one cycle; cnt=MUL_LAT; go to MUL_WAIT.
//   - MUL_WAIT: cnt decrements each cycle. At cnt==1: {hi,lo}<=mul_z, then IDLE.
//   - IDLE + DIV/DIVU with op_b!=0: latch operands; div_start=1 for one cycle; set seen_busy=0; go to DIV_WAIT.
//   - DIV_WAIT: seen_busy<=1 on div_busy. On the first cycle with seen_busy && !div_busy: lo<=div_q, hi<=div_r, then IDLE.
//   - DIV/DIVU with op_b==0: accepted, hi/lo unchanged, no div_start, remain IDLE.
//   - IDLE + MTHI: hi<=op_a. MTLO: lo<=op_a. Single cycle, no stall.
// - rd_data reads the registered hi/lo. An MTxx write and an rd_req in the same IDLE cycle return the old value.
// - Signed edge cases (0x80000000 / -1) pass unchanged to the divider; the result is whatever the divider returns.
// - Signedness is frozen at issue; op_a/op_b may change after accept without effect.
// STRUCTURE
// - muldiv_pkg: op_code localparams (OP_NONE..OP_MTLO), state encodings (ST_IDLE, ST_MUL_WAIT, ST_DIV_WAIT).
// - One sub-module: muldiv_hilo, the HI/LO register pair with sync active-low reset and independent write enables.
// - FSM, latency counter and stall logic stay in this module. No other sub-modules.
// TESTING
// 1. MULT 0xFFFFFFFD*5, MUL_LAT=1 -> mul_start 1 cycle; MUL_LAT+1 cycles later hi=FFFFFFFF, lo=FFFFFFF1.
// 2. MULTU 0xFFFFFFFF*2 -> hi=00000001, lo=FFFFFFFE. Independent op_valid=0/rd_req=0 cycles meanwhile show stall=0.
// 3. DIV 7/-2 with a divider model busy for 33 cycles -> lo=FFFFFFFD, hi=00000001.
//    MFHI (rd_req=1, rd_sel=1) issued 2 cycles after accept holds stall=1 until the cycle after busy falls, then rd_data=00000001.
// 4. DIVU 0x1234/0 -> hi/lo unchanged, div_start never asserted, stall=0.
// 5. MTLO 0xA5A5A5A5 then MFLO next cycle -> rd_data=A5A5A5A5.
//    MTHI issued during MUL_WAIT stalls until the multiply writes, then overwrites hi.
// 6. reset=0 for 1 cycle during DIV_WAIT -> hi=lo=0, stall=0 next cycle.
//    A later fall of div_busy leaves hi/lo at 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: decode op codes,
// FSM states and the latency counter width.
package muldiv_pkg;

  localparam int OP_W  = 3;
  localparam int CNT_W = 4;

  localparam logic [OP_W-1:0] OP_NONE  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULT  = 3'd1;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd3;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd5;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Decode, HI/LO read-back and multiplier/divider engine signals of the sequencer.
// slave = the sequencer, master = decode stage plus the arithmetic engines.
interface muldiv_sequencer_if #(
  parameter int W = 32
) ();
  import muldiv_pkg::*;

  logic            op_valid;
  logic [OP_W-1:0] op_code;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            rd_req;
  logic            rd_sel;
  logic [W-1:0]    rd_data;
  logic            stall;

  logic            mul_start;
  logic            mul_signed;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [2*W-1:0]  mul_z;

  logic            div_start;
  logic            div_signed;
  logic [W-1:0]    div_dividend;
  logic [W-1:0]    div_divisor;
  logic            div_busy;
  logic [W-1:0]    div_q;
  logic [W-1:0]    div_r;

  logic [W-1:0]    hi;
  logic [W-1:0]    lo;

  modport slave (
    input  op_valid, op_code, op_a, op_b, rd_req, rd_sel,
    input  mul_z, div_busy, div_q, div_r,
    output rd_data, stall,
    output mul_start, mul_signed, mul_a, mul_b,
    output div_start, div_signed, div_dividend, div_divisor,
    output hi, lo
  );

  modport master (
    output op_valid, op_code, op_a, op_b, rd_req, rd_sel,
    output mul_z, div_busy, div_q, div_r,
    input  rd_data, stall,
    input  mul_start, mul_signed, mul_a, mul_b,
    input  div_start, div_signed, div_dividend, div_divisor,
    input  hi, lo
  );

endinterface

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO register pair with independent write enables.
module muldiv_hilo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hi_we_i,
  input  logic [W-1:0] hi_d_i,
  input  logic         lo_we_i,
  input  logic [W-1:0] lo_d_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we_i) hi_q <= hi_d_i;
      if (lo_we_i) lo_q <= lo_d_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Issues MULT/DIV ops to external engines, owns HI/LO, and stalls decode only
// when an instruction touches HI/LO while an operation is still in flight.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 1,
  parameter int W       = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_busy_q, seen_busy_d;
  logic               mul_start_q, mul_start_d;
  logic               mul_signed_q, mul_signed_d;
  logic [W-1:0]       mul_a_q, mul_a_d;
  logic [W-1:0]       mul_b_q, mul_b_d;
  logic               div_start_q, div_start_d;
  logic               div_signed_q, div_signed_d;
  logic [W-1:0]       div_dividend_q, div_dividend_d;
  logic [W-1:0]       div_divisor_q, div_divisor_d;

  logic               op_req;
  logic               stall;
  logic               accept;
  logic               hi_we, lo_we;
  logic [W-1:0]       hi_wd, lo_wd;
  logic [W-1:0]       hi, lo;

  assign op_req = bus.op_valid && (bus.op_code != OP_NONE);
  assign stall  = (state_q != ST_IDLE) && (op_req || bus.rd_req);
  assign accept = op_req && !stall;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    seen_busy_d    = seen_busy_q;
    mul_start_d    = 1'b0;
    mul_signed_d   = mul_signed_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    div_start_d    = 1'b0;
    div_signed_d   = div_signed_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d  = div_divisor_q;
    hi_we          = 1'b0;
    lo_we          = 1'b0;
    hi_wd          = bus.op_a;
    lo_wd          = bus.op_a;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.op_code)
            OP_MULT, OP_MULTU: begin
              mul_a_d      = bus.op_a;
              mul_b_d      = bus.op_b;
              mul_signed_d = (bus.op_code == OP_MULT);
              mul_start_d  = 1'b1;
              cnt_d        = CNT_W'(MUL_LAT);
              state_d      = ST_MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              // A zero divisor is swallowed: HI/LO keep their value.
              if (bus.op_b != '0) begin
                div_dividend_d = bus.op_a;
                div_divisor_d  = bus.op_b;
                div_signed_d   = (bus.op_code == OP_DIV);
                div_start_d    = 1'b1;
                seen_busy_d    = 1'b0;
                state_d        = ST_DIV_WAIT;
              end
            end
            OP_MTHI: hi_we = 1'b1;
            OP_MTLO: lo_we = 1'b1;
            default: ;
          endcase
        end
      end

      ST_MUL_WAIT: begin
        // The count starts after the launch pulse so the product is sampled
        // exactly MUL_LAT cycles after mul_start.
        if (!mul_start_q) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            hi_wd   = bus.mul_z[2*W-1:W];
            lo_wd   = bus.mul_z[W-1:0];
            state_d = ST_IDLE;
          end
        end
      end

      ST_DIV_WAIT: begin
        seen_busy_d = seen_busy_q | bus.div_busy;
        if (seen_busy_q && !bus.div_busy) begin
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_wd   = bus.div_r;
          lo_wd   = bus.div_q;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      seen_busy_q    <= 1'b0;
      mul_start_q    <= 1'b0;
      mul_signed_q   <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      div_start_q    <= 1'b0;
      div_signed_q   <= 1'b0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      seen_busy_q    <= seen_busy_d;
      mul_start_q    <= mul_start_d;
      mul_signed_q   <= mul_signed_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      div_start_q    <= div_start_d;
      div_signed_q   <= div_signed_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q  <= div_divisor_d;
    end
  end

  muldiv_hilo #(.W(W)) u_hilo (
    .clk     (clk),
    .reset   (reset),
    .hi_we_i (hi_we),
    .hi_d_i  (hi_wd),
    .lo_we_i (lo_we),
    .lo_d_i  (lo_wd),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign bus.stall        = stall;
  assign bus.rd_data      = bus.rd_sel ? hi : lo;
  assign bus.hi           = hi;
  assign bus.lo           = lo;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_signed   = mul_signed_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.div_start    = div_start_q;
  assign bus.div_signed   = div_signed_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.div_divisor  = div_divisor_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized bench for muldiv_sequencer with behavioural
// multiplier/divider engines and an arithmetic HI/LO reference.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 1;
  localparam logic [63:0] JUNK64 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [31:0] JUNK32 = 32'hBAAD_CAFE;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.W(W)) bus ();

  muldiv_sequencer #(.MUL_LAT(MUL_LAT), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // External multiplier: product valid exactly MUL_LAT cycles after mul_start.
  function automatic logic [63:0] mul_dev(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {32'b0, a} * {32'b0, b};
  endfunction

  logic [63:0] mz_pend;
  int          mz_left = 0;
  always @(posedge clk) begin
    if (bus.mul_start === 1'b1) begin
      mz_pend   <= mul_dev(bus.mul_signed, bus.mul_a, bus.mul_b);
      mz_left   <= MUL_LAT - 1;
      bus.mul_z <= (MUL_LAT == 1) ? mul_dev(bus.mul_signed, bus.mul_a, bus.mul_b) : JUNK64;
    end else if (mz_left > 0) begin
      mz_left   <= mz_left - 1;
      bus.mul_z <= (mz_left == 1) ? mz_pend : JUNK64;
    end else begin
      bus.mul_z <= JUNK64;
    end
  end

  // External divider: busy for div_cyc cycles starting the cycle after div_start.
  function automatic logic [63:0] div_dev(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (sgn) begin
      if (b == 32'hFFFF_FFFF) return {32'h0 - a, 32'h0};
      return {$signed(a) / $signed(b), $signed(a) % $signed(b)};
    end
    return {a / b, a % b};
  endfunction

  int          div_cyc = 33;
  int          dv_left = 0;
  logic [31:0] dq, dr;
  always @(posedge clk) begin
    if (bus.div_start === 1'b1) begin
      bus.div_busy <= 1'b1;
      dv_left      <= div_cyc - 1;
      {dq, dr}     <= div_dev(bus.div_signed, bus.div_dividend, bus.div_divisor);
      bus.div_q    <= JUNK32;
      bus.div_r    <= JUNK32;
    end else if (dv_left > 0) begin
      dv_left <= dv_left - 1;
    end else if (bus.div_busy === 1'b1) begin
      bus.div_busy <= 1'b0;
      bus.div_q    <= dq;
      bus.div_r    <= dr;
    end else begin
      bus.div_busy <= 1'b0;
    end
  end

  // Reference HI/LO after an op completes, from plain arithmetic.
  task automatic ref_apply(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                           inout logic [31:0] h, inout logic [31:0] l);
    longint p;
    int     sa, sb;
    sa = a;
    sb = b;
    case (code)
      OP_MULT:  begin p = longint'(sa) * longint'(sb); {h, l} = p; end
      OP_MULTU: begin p = longint'({32'b0, a}) * longint'({32'b0, b}); {h, l} = p; end
      OP_DIV:   if (b != 0) begin l = sa / sb; h = sa % sb; end
      OP_DIVU:  if (b != 0) begin l = a / b; h = a % b; end
      OP_MTHI:  h = a;
      OP_MTLO:  l = a;
      default:  ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NONE;
    bus.rd_req   = 1'b0;
    bus.rd_sel   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  initial begin
    int          cnt;
    int          gap;
    logic [2:0]  code;
    logic [31:0] a, b;
    logic [31:0] exp_hi, exp_lo;

    idle_in();
    bus.op_a = '0;
    bus.op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_stall", 64'(bus.stall), 64'h0);
    check("rst_mul_start", 64'(bus.mul_start), 64'h0);
    check("rst_div_start", 64'(bus.div_start), 64'h0);
    check("rst_mul_a", 64'(bus.mul_a), 64'h0);
    check("rst_div_dividend", 64'(bus.div_dividend), 64'h0);

    // MULT -3 * 5
    tick();
    idle_in();
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    #1;
    check("t1_issue_stall", 64'(bus.stall), 64'h0);
    tick();
    idle_in();
    bus.op_a = 32'h0;
    #1;
    check("t1_mul_start", 64'(bus.mul_start), 64'h1);
    check("t1_mul_signed", 64'(bus.mul_signed), 64'h1);
    check("t1_mul_a", 64'(bus.mul_a), 64'hFFFF_FFFD);
    check("t1_mul_b", 64'(bus.mul_b), 64'h5);
    tick();
    #1;
    check("t1_pulse_once", 64'(bus.mul_start), 64'h0);
    check("t1_hi_early", 64'(bus.hi), 64'h0);
    tick();
    #1;
    check("t1_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    check("t1_lo", 64'(bus.lo), 64'hFFFF_FFF1);

    // MULTU 0xFFFFFFFF * 2 with unrelated cycles in flight
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    tick();
    idle_in();
    #1;
    check("t2_mul_signed", 64'(bus.mul_signed), 64'h0);
    check("t2_free_stall_a", 64'(bus.stall), 64'h0);
    tick();
    #1;
    check("t2_free_stall_b", 64'(bus.stall), 64'h0);
    tick();
    #1;
    check("t2_hi", 64'(bus.hi), 64'h1);
    check("t2_lo", 64'(bus.lo), 64'hFFFF_FFFE);

    // DIV 7 / -2 with a 33-cycle divider, MFHI two cycles after accept
    div_cyc = 33;
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    tick();
    idle_in();
    #1;
    check("t3_div_start", 64'(bus.div_start), 64'h1);
    check("t3_div_signed", 64'(bus.div_signed), 64'h1);
    check("t3_dividend", 64'(bus.div_dividend), 64'h7);
    check("t3_divisor", 64'(bus.div_divisor), 64'hFFFF_FFFE);
    tick();
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    #1;
    cnt = 0;
    while (bus.stall === 1'b1 && cnt < 200) begin
      cnt = cnt + 1;
      tick();
    end
    check("t3_stall_cycles", 64'(cnt), 64'd34);
    check("t3_mfhi", 64'(bus.rd_data), 64'h1);
    check("t3_lo", 64'(bus.lo), 64'hFFFF_FFFD);

    // DIVU by zero
    idle_in();
    tick();
    issue(OP_DIVU, 32'h1234, 32'h0);
    #1;
    check("t4_issue_stall", 64'(bus.stall), 64'h0);
    tick();
    idle_in();
    bus.rd_req = 1'b1;
    #1;
    check("t4_no_div_start", 64'(bus.div_start), 64'h0);
    check("t4_stall", 64'(bus.stall), 64'h0);
    check("t4_hi", 64'(bus.hi), 64'h1);
    check("t4_lo", 64'(bus.lo), 64'hFFFF_FFFD);

    // MTLO then MFLO; MTHI with same-cycle MFHI returns old HI
    tick();
    idle_in();
    issue(OP_MTLO, 32'hA5A5_A5A5, 32'h0);
    tick();
    idle_in();
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b0;
    #1;
    check("t5_mflo", 64'(bus.rd_data), 64'hA5A5_A5A5);
    tick();
    issue(OP_MTHI, 32'h5A5A_5A5A, 32'h0);
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    #1;
    check("t5_mfhi_old", 64'(bus.rd_data), 64'h1);
    check("t5_mthi_stall", 64'(bus.stall), 64'h0);
    tick();
    idle_in();
    bus.rd_req = 1'b1;
    bus.rd_sel = 1'b1;
    #1;
    check("t5_mfhi_new", 64'(bus.rd_data), 64'h5A5A_5A5A);

    // MTHI during MUL_WAIT waits for the multiply, then overwrites HI
    tick();
    idle_in();
    issue(OP_MULT, 32'd3, 32'd4);
    tick();
    issue(OP_MTHI, 32'h1111, 32'h0);
    #1;
    check("t5_hz_stall_t1", 64'(bus.stall), 64'h1);
    tick();
    check("t5_hz_stall_t2", 64'(bus.stall), 64'h1);
    check("t5_hz_hi_held", 64'(bus.hi), 64'h5A5A_5A5A);
    tick();
    check("t5_hz_stall_t3", 64'(bus.stall), 64'h0);
    check("t5_hz_mul_hi", 64'(bus.hi), 64'h0);
    check("t5_hz_mul_lo", 64'(bus.lo), 64'hC);
    tick();
    idle_in();
    #1;
    check("t5_hz_mthi", 64'(bus.hi), 64'h1111);
    check("t5_hz_lo_kept", 64'(bus.lo), 64'hC);

    // Reset during DIV_WAIT discards the in-flight result
    div_cyc = 33;
    issue(OP_DIV, 32'd100, 32'd7);
    tick();
    idle_in();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    check("t6_hi", 64'(bus.hi), 64'h0);
    check("t6_lo", 64'(bus.lo), 64'h0);
    check("t6_stall", 64'(bus.stall), 64'h0);
    repeat (40) tick();
    check("t6_late_hi", 64'(bus.hi), 64'h0);
    check("t6_late_lo", 64'(bus.lo), 64'h0);
    check("t6_late_stall", 64'(bus.stall), 64'h0);

    // Randomized ops, each followed by a MFHI/MFLO that must wait for the result
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    for (int it = 0; it < 60; it++) begin
      code = 3'($urandom_range(1, 6));
      a    = $urandom;
      b    = $urandom;
      if ((code == OP_DIV || code == OP_DIVU) && $urandom_range(0, 4) == 0) b = 32'h0;
      if (code == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
      ref_apply(code, a, b, exp_hi, exp_lo);
      div_cyc = $urandom_range(1, 6);
      tick();
      idle_in();
      issue(code, a, b);
      tick();
      idle_in();
      bus.op_a = $urandom;
      bus.op_b = $urandom;
      #1;
      check("rnd_free_stall", 64'(bus.stall), 64'h0);
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      tick();
      bus.rd_req = 1'b1;
      bus.rd_sel = 1'($urandom_range(0, 1));
      #1;
      cnt = 0;
      while (bus.stall === 1'b1 && cnt < 100) begin
        cnt = cnt + 1;
        tick();
      end
      check("rnd_wait_bound", 64'(cnt < 100), 64'h1);
      check("rnd_rd_data", 64'(bus.rd_data), 64'(bus.rd_sel ? exp_hi : exp_lo));
      check("rnd_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
